// File: rtl/rwc_pkg.sv
// Shared types and constants for the read-write collision challenge path.
// Used by the sequencer and the host-side challenge generator.
package rwc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_LO,
      WAIT_HI,
      CAPTURE,
      OUTPUT,
      DONE
   } state_t;

   localparam logic [31:0] LFSR_POLY     = 32'h80200003;
   localparam logic [31:0] LFSR_ZERO_SUB = 32'h1;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/rwc_chal_seq_if.sv
// Generator request/response bundle plus upstream response handshake.
// master = sequencer side, slave = generator/consumer side.
interface rwc_chal_seq_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              gen_enable;
   logic [DATA_W-1:0] cha_data;
   logic [ADDR_W-1:0] cha_addr;
   logic              available;
   logic [DATA_W-1:0] rsp_pos;
   logic [DATA_W-1:0] rsp_neg;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [7:0]        resp_idx;
   logic              resp_ready;

   modport master (
      output gen_enable, cha_data, cha_addr,
      output resp_valid, resp_data, resp_idx,
      input  available, rsp_pos, rsp_neg, resp_ready
   );

   modport slave (
      input  gen_enable, cha_data, cha_addr,
      input  resp_valid, resp_data, resp_idx,
      output available, rsp_pos, rsp_neg, resp_ready
   );
endinterface

// File: rtl/rwc_lfsr32.sv
// 32-bit Galois LFSR with load/step; a zero seed is replaced so the
// register can never lock up in the all-zero state.
module rwc_lfsr32
   import rwc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LFSR_ZERO_SUB;
      end else if (load) begin
         state <= (seed == 32'h0) ? LFSR_ZERO_SUB : seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/rwc_chal_seq.sv
// Challenge sequencer: issues NUM_CHAL LFSR challenges to the generator
// and returns rsp_pos ^ rsp_neg per challenge over valid/ready.
module rwc_chal_seq
   import rwc_pkg::*;
#(
   parameter int NUM_CHAL = 8,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       seed,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   rwc_chal_seq_if.master    bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0] I_LAST = 8'(NUM_CHAL - 1);

   state_t            state_q;
   state_t            state_d;
   logic [31:0]       lfsr;
   logic              lfsr_load;
   logic              lfsr_step;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        idx;
   logic [TW-1:0]     tcnt;
   logic              hs;
   logic              t_exp;

   assign hs    = bus.resp_valid && bus.resp_ready;
   assign t_exp = (tcnt == T_LAST);
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);

   rwc_lfsr32 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .seed  (seed),
      .step  (lfsr_step),
      .state (lfsr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               lfsr_load = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.available) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (t_exp)               state_d = DONE;
            else if (!bus.available) state_d = WAIT_HI;
         end
         // reaching CAPTURE on the last allowed cycle still counts
         WAIT_HI: begin
            if (bus.available) state_d = CAPTURE;
            else if (t_exp)    state_d = DONE;
         end
         CAPTURE: state_d = OUTPUT;
         OUTPUT: begin
            if (hs) begin
               lfsr_step = 1'b1;
               state_d   = (idx == I_LAST) ? DONE : ISSUE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.gen_enable <= 1'b0;
         bus.cha_data   <= '0;
         bus.cha_addr   <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_idx   <= '0;
         err            <= 1'b0;
         addr           <= '0;
         idx            <= '0;
         tcnt           <= '0;
      end else begin
         bus.gen_enable <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  addr <= base_addr;
                  idx  <= '0;
                  err  <= 1'b0;
               end
            end
            ISSUE: begin
               if (bus.available) begin
                  bus.gen_enable <= 1'b1;
                  bus.cha_data   <= DATA_W'(lfsr);
                  bus.cha_addr   <= addr;
                  tcnt           <= '0;
               end
            end
            WAIT_LO, WAIT_HI: begin
               tcnt <= tcnt + 1'b1;
               if (state_d == DONE) begin
                  err          <= 1'b1;
                  bus.cha_data <= '0;
                  bus.cha_addr <= '0;
               end
            end
            CAPTURE: begin
               bus.resp_data  <= bus.rsp_pos ^ bus.rsp_neg;
               bus.resp_idx   <= idx;
               bus.resp_valid <= 1'b1;
            end
            OUTPUT: begin
               if (hs) begin
                  bus.resp_valid <= 1'b0;
                  addr           <= addr + 1'b1;
                  idx            <= idx + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rwc_chal_seq.sv
// Directed bench for rwc_chal_seq with a 4-cycle generator model.
module tb_rwc_chal_seq;

   localparam int NC = 4;
   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct {
      logic [31:0]         seed;
      logic [9:0]          base;
      logic [31:0]         pos;
      logic [31:0]         neg;
      logic [31:0]         rd;
      bit                  poke;
      logic [3:0][31:0]    d;
      logic [3:0][9:0]     a;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] seed = '0;
   logic [9:0]  base_addr = '0;
   logic        busy;
   logic        done;
   logic        err;

   rwc_chal_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   rwc_chal_seq #(
      .NUM_CHAL (NC),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .TIMEOUT  (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .seed      (seed),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // generator model: leaves idle for 4 cycles per request
   logic       hang = 1'b0;
   logic       gm_clr = 1'b1;
   logic [2:0] gcnt;

   always @(posedge clk) begin
      if (gm_clr) begin
         bus.available <= 1'b1;
         gcnt          <= '0;
      end else if (gcnt != 0) begin
         gcnt <= gcnt - 3'd1;
         if (gcnt == 3'd1 && !hang) bus.available <= 1'b1;
      end else if (bus.gen_enable && bus.available) begin
         bus.available <= 1'b0;
         gcnt          <= 3'd4;
      end
   end

   logic [31:0] q_d[$];
   logic [31:0] q_a[$];
   logic [31:0] q_rd[$];
   logic [31:0] q_ri[$];
   int          done_cnt = 0;
   int          cyc = 0;
   int          ge_cyc = 0;
   int          err_cyc = 0;
   logic        prev_ge = 1'b0;
   logic        prev_err = 1'b0;

   always @(negedge clk) begin
      #2;
      cyc++;
      if (bus.gen_enable) begin
         chk("gen_enable_single", 32'(prev_ge), 32'h0);
         q_d.push_back(bus.cha_data);
         q_a.push_back(32'(bus.cha_addr));
         ge_cyc = cyc;
      end
      if (bus.resp_valid && bus.resp_ready) begin
         q_rd.push_back(bus.resp_data);
         q_ri.push_back(32'(bus.resp_idx));
      end
      if (done) done_cnt++;
      if (err && !prev_err) err_cyc = cyc;
      prev_ge  = bus.gen_enable;
      prev_err = err;
   end

   task automatic clear_mon();
      q_d.delete();
      q_a.delete();
      q_rd.delete();
      q_ri.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [9:0] b);
      @(negedge clk);
      seed      = s;
      base_addr = b;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input bit poke);
      int i;
      for (i = 0; i < 300 && done_cnt == 0; i++) begin
         @(negedge clk);
         start = poke && (i == 3 || i == 12 || i == 25);
         if (start) begin
            seed      = 32'h5555AAAA;
            base_addr = 10'h155;
         end
      end
      start = 1'b0;
      chk({nm, "_done_seen"}, 32'(done_cnt != 0), 32'h1);
      @(negedge clk);
      #3;
      chk({nm, "_busy_after"}, 32'(busy), 32'h0);
      chk({nm, "_done_once"}, 32'(done_cnt), 32'h1);
   endtask

   vec_t vec[3];
   logic [31:0] snap;
   int          gsnap;
   bit          bad_v;
   bit          bad_d;
   int          n;

   initial begin
      vec[0].seed = 32'hDEADBEEF; vec[0].base = 10'h3FE;
      vec[0].pos  = 32'hF0F0F0F0; vec[0].neg  = 32'hFF00FF00;
      vec[0].rd   = 32'h0FF00FF0; vec[0].poke = 1'b0;
      vec[0].d[0] = 32'hDEADBEEF; vec[0].d[1] = 32'hEF76DF74;
      vec[0].d[2] = 32'h77BB6FBA; vec[0].d[3] = 32'h3BDDB7DD;
      vec[0].a[0] = 10'h3FE; vec[0].a[1] = 10'h3FF;
      vec[0].a[2] = 10'h000; vec[0].a[3] = 10'h001;

      vec[1].seed = 32'h0; vec[1].base = 10'h000;
      vec[1].pos  = 32'h12345678; vec[1].neg = 32'h12345678;
      vec[1].rd   = 32'h0; vec[1].poke = 1'b0;
      vec[1].d[0] = 32'h00000001; vec[1].d[1] = 32'h80200003;
      vec[1].d[2] = 32'hC0300002; vec[1].d[3] = 32'h60180001;
      vec[1].a[0] = 10'h000; vec[1].a[1] = 10'h001;
      vec[1].a[2] = 10'h002; vec[1].a[3] = 10'h003;

      vec[2].seed = 32'h2; vec[2].base = 10'h100;
      vec[2].pos  = 32'hAAAAAAAA; vec[2].neg = 32'h55555555;
      vec[2].rd   = 32'hFFFFFFFF; vec[2].poke = 1'b1;
      vec[2].d[0] = 32'h00000002; vec[2].d[1] = 32'h00000001;
      vec[2].d[2] = 32'h80200003; vec[2].d[3] = 32'hC0300002;
      vec[2].a[0] = 10'h100; vec[2].a[1] = 10'h101;
      vec[2].a[2] = 10'h102; vec[2].a[3] = 10'h103;

      bus.rsp_pos    = '0;
      bus.rsp_neg    = '0;
      bus.resp_ready = 1'b1;

      #1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_gen_enable", 32'(bus.gen_enable), 32'h0);
      chk("rst_cha_data", bus.cha_data, 32'h0);
      chk("rst_cha_addr", 32'(bus.cha_addr), 32'h0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_resp_data", bus.resp_data, 32'h0);
      chk("rst_resp_idx", 32'(bus.resp_idx), 32'h0);

      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      gm_clr = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 3; v++) begin
         bus.rsp_pos = vec[v].pos;
         bus.rsp_neg = vec[v].neg;
         clear_mon();
         pulse_start(vec[v].seed, vec[v].base);
         wait_done($sformatf("v%0d", v), vec[v].poke);
         chk($sformatf("v%0d_n_cha", v), 32'(q_d.size()), 32'(NC));
         chk($sformatf("v%0d_n_rsp", v), 32'(q_rd.size()), 32'(NC));
         for (int j = 0; j < NC; j++) begin
            chk($sformatf("v%0d_cha_data%0d", v, j),
                (q_d.size() > j) ? q_d[j] : 32'hXXXXXXXX, vec[v].d[j]);
            chk($sformatf("v%0d_cha_addr%0d", v, j),
                (q_a.size() > j) ? q_a[j] : 32'hXXXXXXXX, 32'(vec[v].a[j]));
            chk($sformatf("v%0d_resp_idx%0d", v, j),
                (q_ri.size() > j) ? q_ri[j] : 32'hXXXXXXXX, 32'(j));
            chk($sformatf("v%0d_resp_data%0d", v, j),
                (q_rd.size() > j) ? q_rd[j] : 32'hXXXXXXXX, vec[v].rd);
         end
         chk($sformatf("v%0d_err", v), 32'(err), 32'h0);
      end

      // backpressure: response held, no new request issued
      bus.rsp_pos    = 32'hF0F0F0F0;
      bus.rsp_neg    = 32'hFF00FF00;
      bus.resp_ready = 1'b0;
      clear_mon();
      pulse_start(32'hDEADBEEF, 10'h3FE);
      n = 0;
      while (!bus.resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid_seen", 32'(bus.resp_valid), 32'h1);
      snap  = bus.resp_data;
      gsnap = q_d.size();
      bad_v = 1'b0;
      bad_d = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b1) bad_v = 1'b1;
         if (bus.resp_data !== snap) bad_d = 1'b1;
      end
      chk("stall_resp_data", snap, 32'h0FF00FF0);
      chk("stall_valid_stable", 32'(bad_v), 32'h0);
      chk("stall_data_stable", 32'(bad_d), 32'h0);
      chk("stall_no_gen", 32'(q_d.size()), 32'(gsnap));
      chk("stall_idx", 32'(bus.resp_idx), 32'h0);
      bus.resp_ready = 1'b1;
      wait_done("stall", 1'b0);
      chk("stall_n_rsp", 32'(q_rd.size()), 32'(NC));

      // generator never returns to idle
      hang = 1'b1;
      clear_mon();
      pulse_start(32'h12345678, 10'h010);
      wait_done("tmo", 1'b0);
      chk("tmo_err", 32'(err), 32'h1);
      chk("tmo_latency", 32'(err_cyc - ge_cyc), 32'd16);
      chk("tmo_no_rsp", 32'(q_rd.size()), 32'h0);
      chk("tmo_n_cha", 32'(q_d.size()), 32'h1);
      chk("tmo_gen_off", 32'(bus.gen_enable), 32'h0);
      chk("tmo_cha_addr", 32'(bus.cha_addr), 32'h0);
      @(negedge clk);
      hang   = 1'b0;
      gm_clr = 1'b1;
      @(negedge clk);
      gm_clr = 1'b0;
      clear_mon();
      pulse_start(32'h00000002, 10'h100);
      chk("tmo_err_cleared", 32'(err), 32'h0);
      wait_done("tmo_recover", 1'b0);
      chk("tmo_recover_n_rsp", 32'(q_rd.size()), 32'(NC));

      // asynchronous reset while waiting for the generator to finish
      clear_mon();
      pulse_start(32'hDEADBEEF, 10'h3FE);
      n = 0;
      while (q_d.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      #3;
      chk("ar_pre_busy", 32'(busy), 32'h1);
      chk("ar_pre_avail", 32'(bus.available), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'h0);
      chk("ar_cha_data", bus.cha_data, 32'h0);
      chk("ar_cha_addr", 32'(bus.cha_addr), 32'h0);
      chk("ar_gen_enable", 32'(bus.gen_enable), 32'h0);
      chk("ar_resp_valid", 32'(bus.resp_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      clear_mon();
      pulse_start(32'hDEADBEEF, 10'h3FE);
      wait_done("ar_rerun", 1'b0);
      chk("ar_rerun_idx0",
          (q_ri.size() > 0) ? q_ri[0] : 32'hXXXXXXXX, 32'h0);
      chk("ar_rerun_cha0",
          (q_d.size() > 0) ? q_d[0] : 32'hXXXXXXXX, 32'hDEADBEEF);
      chk("ar_rerun_n_rsp", 32'(q_rd.size()), 32'(NC));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
